// File: rtl/hex_display_sched_if.sv
// Signal bundle between the SoC side and the seven-segment page scheduler.
// The master drives the SoC/status inputs; the scheduler (slave) drives the display.
interface hex_display_sched_if;
    logic [15:0] DataOut;
    logic        DataValid;
    logic        LOCKUP;
    logic        Running;
    logic        Heartbeat;
    logic        PageKey;
    logic [7:0]  HEX0;
    logic [7:0]  HEX1;
    logic [7:0]  HEX2;
    logic [7:0]  HEX3;
    logic [1:0]  Page;

    modport master (
        output DataOut, DataValid, LOCKUP, Running, Heartbeat, PageKey,
        input  HEX0, HEX1, HEX2, HEX3, Page
    );

    modport slave (
        input  DataOut, DataValid, LOCKUP, Running, Heartbeat, PageKey,
        output HEX0, HEX1, HEX2, HEX3, Page
    );
endinterface

// File: rtl/hex_display_sched.sv
// Picks which page (DATA / STATUS / LOCK) the four DE0 digits show, with
// lockup > key press > new data > dwell timeout priority and a debounced page key.
module hex_display_sched #(
    parameter int DWELL_CYCLES    = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    hex_display_sched_if.slave  bus
);
    localparam int DW_W = (DWELL_CYCLES    > 2) ? $clog2(DWELL_CYCLES)    : 1;
    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_R     = 7'h50;
    localparam logic [6:0] SEG_L     = 7'h38;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        S_DATA   = 2'd0,
        S_STATUS = 2'd1,
        S_LOCK   = 2'd2
    } state_t;

    function automatic logic [6:0] f_font(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
            4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
            4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
            4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Page key: 2-flop synchroniser, then a level that flips only after a
    // full run of differing samples; any bounce back restarts the count.
    logic            r_key_s1, r_key_s2, r_key_db, r_key_db_d;
    logic [DB_W-1:0] r_db_cnt;
    logic            w_press;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_key_s1   <= 1'b0;
            r_key_s2   <= 1'b0;
            r_key_db   <= 1'b0;
            r_key_db_d <= 1'b0;
            r_db_cnt   <= '0;
        end else begin
            r_key_s1   <= bus.PageKey;
            r_key_s2   <= r_key_s1;
            r_key_db_d <= r_key_db;
            if (r_key_s2 != r_key_db) begin
                if (r_db_cnt == DB_LAST) begin
                    r_key_db <= r_key_s2;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    assign w_press = r_key_db & ~r_key_db_d;

    logic [15:0] r_data;
    logic        r_seen, r_dv_d;
    logic        w_new_data;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_data <= 16'h0000;
            r_seen <= 1'b0;
            r_dv_d <= 1'b0;
        end else begin
            r_dv_d <= bus.DataValid;
            if (bus.DataValid) begin
                r_data <= bus.DataOut;
                r_seen <= 1'b1;
            end
        end
    end

    assign w_new_data = bus.DataValid & ~r_dv_d;

    state_t          r_state;
    logic [DW_W-1:0] r_dwell;
    state_t          w_toggle;

    assign w_toggle = (r_state == S_DATA) ? S_STATUS : S_DATA;

    // One event wins per cycle; anything lower priority is simply dropped.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= S_STATUS;
            r_dwell <= '0;
        end else if (bus.LOCKUP) begin
            r_state <= S_LOCK;
            r_dwell <= '0;
        end else if (r_state == S_LOCK) begin
            r_state <= S_STATUS;
            r_dwell <= '0;
        end else if (w_press) begin
            r_state <= w_toggle;
            r_dwell <= '0;
        end else if (w_new_data) begin
            r_state <= S_DATA;
            r_dwell <= '0;
        end else if (r_dwell == DW_LAST) begin
            r_state <= w_toggle;
            r_dwell <= '0;
        end else begin
            r_dwell <= r_dwell + 1'b1;
        end
    end

    logic [3:0][6:0] w_seg;
    logic            w_dp;

    always_comb begin
        w_seg = {4{SEG_BLANK}};
        w_dp  = 1'b0;
        case (r_state)
            S_DATA: begin
                if (r_seen) begin
                    w_seg[3] = f_font(r_data[15:12]);
                    w_seg[2] = f_font(r_data[11:8]);
                    w_seg[1] = f_font(r_data[7:4]);
                    w_seg[0] = f_font(r_data[3:0]);
                end else begin
                    w_seg = {4{SEG_DASH}};
                end
                w_dp = bus.Heartbeat;
            end
            S_STATUS: begin
                w_seg[3] = bus.Running   ? SEG_R : SEG_BLANK;
                w_seg[1] = bus.DataValid ? SEG_D : SEG_BLANK;
                w_dp     = bus.Heartbeat;
            end
            S_LOCK: begin
                w_seg = {SEG_L, SEG_DASH, SEG_DASH, SEG_DASH};
            end
            default: ;
        endcase
    end

    // Display and page are registered so the pins never see decode glitches.
    logic [3:0][7:0] r_hex;
    logic [1:0]      r_page;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_hex  <= {4{8'hFF}};
            r_page <= 2'd1;
        end else begin
            r_hex[3] <= ~{1'b0, w_seg[3]};
            r_hex[2] <= ~{1'b0, w_seg[2]};
            r_hex[1] <= ~{1'b0, w_seg[1]};
            r_hex[0] <= ~{w_dp, w_seg[0]};
            r_page   <= r_state;
        end
    end

    assign bus.HEX3 = r_hex[3];
    assign bus.HEX2 = r_hex[2];
    assign bus.HEX1 = r_hex[1];
    assign bus.HEX0 = r_hex[0];
    assign bus.Page = r_page;
endmodule

// File: tb/tb_hex_display_sched.sv
// Scoreboard bench for hex_display_sched: stimulus pushes expected page/HEX
// values tagged with the clock edge they are due on; a monitor pops and compares.
module tb_hex_display_sched;
    logic HCLK;
    logic HRESETn;
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;

    hex_display_sched_if bus ();

    hex_display_sched #(.DWELL_CYCLES(16), .DEBOUNCE_CYCLES(4)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        string       tag;
        int          cyc;
        logic [1:0]  page;
        logic [31:0] hex;
        bit          chk_hex;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, want, cyc);
        end
    endtask

    task automatic exp_at(input string tag, input int t, input logic [1:0] page,
                          input logic [31:0] hex, input bit chk_hex);
        exp_t e;
        e.tag = tag; e.cyc = t; e.page = page; e.hex = hex; e.chk_hex = chk_hex;
        sb.push_back(e);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge HCLK);
    endtask

    function automatic logic [31:0] hex_all();
        return {bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0};
    endfunction

    // Monitor: one edge count per posedge, compare entries due on that edge.
    initial begin
        forever begin
            @(posedge HCLK);
            #1;
            cyc++;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == cyc) begin
                    chk({sb[i].tag, "_page"}, {30'd0, bus.Page}, {30'd0, sb[i].page});
                    if (sb[i].chk_hex) chk({sb[i].tag, "_hex"}, hex_all(), sb[i].hex);
                    sb.delete(i);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    localparam logic [31:0] H_STATUS = 32'hAF_FF_FF_FF;
    localparam logic [31:0] H_STAT_H = 32'hAF_FF_FF_7F;
    localparam logic [31:0] H_DASH   = 32'hBF_BF_BF_BF;
    localparam logic [31:0] H_BEEF   = 32'h83_86_86_8E;
    localparam logic [31:0] H_1234H  = 32'hF9_A4_B0_19;
    localparam logic [31:0] H_5678H  = 32'h92_82_F8_00;
    localparam logic [31:0] H_LOCK   = 32'hC7_BF_BF_BF;

    int c, n, m, k, lk, r;

    initial begin
        HRESETn       = 1'b0;
        bus.DataOut   = 16'h0000;
        bus.DataValid = 1'b0;
        bus.LOCKUP    = 1'b0;
        bus.Running   = 1'b1;
        bus.Heartbeat = 1'b0;
        bus.PageKey   = 1'b0;

        wait_cyc(3);
        chk("reset_page", {30'd0, bus.Page}, 32'd1);
        chk("reset_hex", hex_all(), 32'hFFFF_FFFF);

        // Idle dwell: STATUS, then DATA (dashes), then STATUS again.
        c = cyc;
        HRESETn = 1'b1;
        exp_at("idle_status",  c + 1,  2'd1, H_STATUS, 1);
        exp_at("idle_hold",    c + 16, 2'd1, H_STATUS, 1);
        exp_at("idle_dash",    c + 17, 2'd0, H_DASH,   1);
        exp_at("idle_hold2",   c + 32, 2'd0, H_DASH,   1);
        exp_at("idle_back",    c + 33, 2'd1, H_STATUS, 1);
        wait_cyc(c + 33);

        // Data pulse from STATUS jumps to DATA and restarts the dwell.
        n = cyc;
        bus.DataOut   = 16'hBEEF;
        bus.DataValid = 1'b1;
        exp_at("dv_status_d",  n + 1,  2'd1, 32'hAF_FF_A1_FF, 1);
        exp_at("dv_data",      n + 2,  2'd0, H_BEEF,   1);
        exp_at("dv_dwell_hold",n + 17, 2'd0, H_BEEF,   1);
        exp_at("dv_dwell_adv", n + 18, 2'd1, H_STATUS, 1);
        wait_cyc(n + 1);
        bus.DataValid = 1'b0;
        wait_cyc(n + 18);

        // Short bounce: no toggle; dwell alone advances the page.
        m = cyc;
        bus.PageKey = 1'b1;
        exp_at("bounce_hold",  m + 14, 2'd1, H_STATUS, 1);
        exp_at("bounce_dwell", m + 16, 2'd0, H_BEEF,   1);
        wait_cyc(m + 3);
        bus.PageKey = 1'b0;
        wait_cyc(m + 16);

        // Long press: exactly one toggle; release does nothing.
        k = cyc;
        bus.PageKey = 1'b1;
        exp_at("key_before",   k + 7,  2'd0, H_BEEF,   1);
        exp_at("key_toggle",   k + 8,  2'd1, H_STATUS, 1);
        exp_at("key_release",  k + 20, 2'd1, H_STATUS, 1);
        exp_at("key_dwell",    k + 24, 2'd0, H_BEEF,   1);
        wait_cyc(k + 10);
        bus.PageKey = 1'b0;
        wait_cyc(k + 24);

        // Lockup overrides a press and new data; heartbeat hidden in LOCK.
        lk = cyc;
        bus.LOCKUP    = 1'b1;
        bus.PageKey   = 1'b1;
        bus.DataOut   = 16'h1234;
        bus.DataValid = 1'b1;
        bus.Heartbeat = 1'b1;
        exp_at("lock_enter",   lk + 2,  2'd2, H_LOCK,   1);
        exp_at("lock_hold",    lk + 45, 2'd2, H_LOCK,   1);
        exp_at("unlock_wait",  lk + 46, 2'd2, H_LOCK,   1);
        exp_at("unlock",       lk + 47, 2'd1, H_STAT_H, 1);
        exp_at("hb_data",      lk + 63, 2'd0, H_1234H,  1);
        wait_cyc(lk + 2);
        bus.DataValid = 1'b0;
        wait_cyc(lk + 10);
        bus.PageKey = 1'b0;
        wait_cyc(lk + 45);
        bus.LOCKUP = 1'b0;

        // Press, new data and dwell expiry all land on edge lk+78.
        exp_at("coinc_pre",    lk + 78, 2'd0, H_1234H,  1);
        exp_at("coinc_press",  lk + 79, 2'd1, H_STAT_H, 1);
        exp_at("coinc_cnt0",   lk + 94, 2'd1, H_STAT_H, 1);
        exp_at("coinc_dwell",  lk + 95, 2'd0, H_5678H,  1);
        exp_at("pre_rst",      lk + 99, 2'd0, H_5678H,  1);
        wait_cyc(lk + 71);
        bus.PageKey = 1'b1;
        wait_cyc(lk + 77);
        bus.DataOut   = 16'h5678;
        bus.DataValid = 1'b1;
        wait_cyc(lk + 78);
        bus.DataValid = 1'b0;
        wait_cyc(lk + 81);
        bus.PageKey = 1'b0;

        // Asynchronous reset mid-dwell in DATA.
        wait_cyc(lk + 100);
        HRESETn = 1'b0;
        #1;
        chk("rst_async_page", {30'd0, bus.Page}, 32'd1);
        chk("rst_async_hex", hex_all(), 32'hFFFF_FFFF);
        wait_cyc(lk + 102);
        r = cyc;
        HRESETn = 1'b1;
        exp_at("post_rst",      r + 1,  2'd1, H_STAT_H, 1);
        exp_at("post_rst_dash", r + 17, 2'd0, 32'hBF_BF_BF_3F, 1);
        exp_at("run_off",       r + 33, 2'd1, 32'hFF_FF_FF_7F, 1);
        wait_cyc(r + 17);
        bus.Running = 1'b0;
        wait_cyc(r + 35);

        chk("sb_drain", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
